// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Single outstanding imem request; a one-entry hold buffer absorbs a response while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [6:0]  if_opcode,
    output logic [2:0]  if_f3
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] hold_instr, hold_instr_n;
    logic [31:0] hold_pc, hold_pc_n;
    logic        valid_n;
    logic [31:0] instr_n;
    logic [31:0] ifpc_n;
    logic        load_ok;
    logic        unused_redirect_lsbs;

    // Redirect targets are word aligned; the low bits are dropped by design.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign load_ok     = ~if_valid | ~stall;
    assign imem_req    = (state == S_REQ) & ~rst;
    assign imem_addr   = pc;
    assign if_pc_plus4 = if_pc + 32'd4;
    assign if_opcode   = if_instr[6:0];
    assign if_f3       = if_instr[14:12];

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        hold_instr_n = hold_instr;
        hold_pc_n    = hold_pc;
        valid_n      = if_valid & stall;
        instr_n      = (if_valid & stall) ? if_instr : NOP_INSTR;
        ifpc_n       = if_pc;

        if (redirect) begin
            pc_n         = {redirect_pc[31:2], 2'b00};
            valid_n      = 1'b0;
            instr_n      = NOP_INSTR;
            hold_instr_n = NOP_INSTR;
            hold_pc_n    = '0;
            // A request already accepted by memory must have its response drained.
            unique case (state)
                S_REQ:   state_n = imem_ready  ? S_DRAIN : S_REQ;
                S_WAIT:  state_n = imem_rvalid ? S_REQ   : S_DRAIN;
                S_HOLD:  state_n = S_REQ;
                S_DRAIN: state_n = S_DRAIN;
                default: state_n = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem_ready) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_n = pc + 32'd4;
                        if (load_ok) begin
                            valid_n = 1'b1;
                            instr_n = imem_rdata;
                            ifpc_n  = pc;
                            state_n = S_REQ;
                        end else begin
                            hold_instr_n = imem_rdata;
                            hold_pc_n    = pc;
                            state_n      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (load_ok) begin
                        valid_n = 1'b1;
                        instr_n = hold_instr;
                        ifpc_n  = hold_pc;
                        state_n = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_n = S_REQ;
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
            if_pc      <= RESET_PC;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            hold_instr <= hold_instr_n;
            hold_pc    <= hold_pc_n;
            if_valid   <= valid_n;
            if_instr   <= instr_n;
            if_pc      <= ifpc_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the instruction memory is driven by hand, cycle by cycle.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [6:0]  if_opcode;
    logic [2:0]  if_f3;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage #(
        .RESET_PC  (32'h0000_0100),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_opcode   (if_opcode),
        .if_f3       (if_f3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem(input logic rdy, input logic rv, input logic [31:0] rd);
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = rd;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem(1'b0, 1'b0, '0);
        #3;
        chk("rst_req",    {31'b0, imem_req}, 32'd0);
        chk("rst_valid",  {31'b0, if_valid}, 32'd0);
        chk("rst_instr",  if_instr,          NOP);
        chk("rst_pc",     if_pc,             32'h100);
        chk("rst_pc4",    if_pc_plus4,       32'h104);
        chk("rst_addr",   imem_addr,         32'h100);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("req_after_rst", {31'b0, imem_req}, 32'd1);

        // Sequential fetches with ready=1, k=1, rdata=addr
        mem(1'b1, 1'b0, '0);
        tick();
        chk("wait_noreq", {31'b0, imem_req}, 32'd0);
        mem(1'b0, 1'b1, 32'h100);
        tick();
        chk("f0_valid", {31'b0, if_valid}, 32'd1);
        chk("f0_pc",    if_pc,             32'h100);
        chk("f0_instr", if_instr,          32'h100);
        chk("f0_pc4",   if_pc_plus4,       32'h104);
        chk("f0_addr",  imem_addr,         32'h104);
        mem(1'b1, 1'b0, '0);
        tick();
        chk("f0_consumed", {31'b0, if_valid}, 32'd0);
        mem(1'b0, 1'b1, 32'h104);
        tick();
        chk("f1_pc",    if_pc,       32'h104);
        chk("f1_instr", if_instr,    32'h104);
        chk("f1_pc4",   if_pc_plus4, 32'h108);
        chk("f1_addr",  imem_addr,   32'h108);

        // Decoder field slicing
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b1, 32'h00A0_0093);
        tick();
        chk("addi_valid",  {31'b0, if_valid},  32'd1);
        chk("addi_opcode", {25'b0, if_opcode}, 32'h13);
        chk("addi_f3",     {29'b0, if_f3},     32'd0);
        chk("addi_pc",     if_pc,              32'h108);

        // Stall for 5 cycles while a second response lands in the hold buffer
        stall = 1'b1;
        mem(1'b1, 1'b0, '0);
        tick();
        chk("stall_held_valid", {31'b0, if_valid}, 32'd1);
        mem(1'b0, 1'b1, 32'hDEAD_0001);
        tick();
        mem(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_noreq", {31'b0, imem_req}, 32'd0);
            chk("hold_instr", if_instr,          32'h00A0_0093);
            tick();
        end
        chk("hold_valid", {31'b0, if_valid}, 32'd1);
        stall = 1'b0;
        tick();
        chk("unhold_valid", {31'b0, if_valid}, 32'd1);
        chk("unhold_instr", if_instr,          32'hDEAD_0001);
        chk("unhold_pc",    if_pc,             32'h10C);
        chk("unhold_req",   {31'b0, imem_req}, 32'd1);
        chk("unhold_addr",  imem_addr,         32'h110);
        tick();
        chk("no_dup_valid", {31'b0, if_valid}, 32'd0);
        chk("no_dup_instr", if_instr,          NOP);

        // Redirect while waiting with no response: stale response must be drained
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b0, '0);
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        chk("rd1_valid", {31'b0, if_valid}, 32'd0);
        chk("rd1_noreq", {31'b0, imem_req}, 32'd0);
        chk("rd1_addr",  imem_addr,         32'h200);
        mem(1'b0, 1'b1, 32'h0000_0BAD);
        tick();
        chk("drain_valid", {31'b0, if_valid}, 32'd0);
        chk("drain_req",   {31'b0, imem_req}, 32'd1);
        chk("drain_addr",  imem_addr,         32'h200);
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b1, 32'h1111_1111);
        tick();
        chk("rd1_first_pc",    if_pc,    32'h200);
        chk("rd1_first_instr", if_instr, 32'h1111_1111);

        // Redirect coincident with rvalid and stall: redirect wins, response dropped
        stall = 1'b1;
        mem(1'b1, 1'b0, '0);
        tick();
        chk("rd2_pre_valid", {31'b0, if_valid}, 32'd1);
        mem(1'b0, 1'b1, 32'h2222_2222);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0; stall = 1'b0;
        mem(1'b0, 1'b0, '0);
        chk("rd2_valid", {31'b0, if_valid}, 32'd0);
        chk("rd2_instr", if_instr,          NOP);
        chk("rd2_req",   {31'b0, imem_req}, 32'd1);
        chk("rd2_addr",  imem_addr,         32'h300);
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b1, 32'h0000_0033);
        tick();
        chk("rd2_first_pc",    if_pc,    32'h300);
        chk("rd2_first_instr", if_instr, 32'h0000_0033);

        // PC wrap at the top of the address space
        mem(1'b0, 1'b0, '0);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_req",  {31'b0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr,         32'hFFFF_FFFC);
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b1, 32'h0000_0044);
        tick();
        chk("wrap_pc",      if_pc,       32'hFFFF_FFFC);
        chk("wrap_pc4",     if_pc_plus4, 32'h0000_0000);
        chk("wrap_nextadr", imem_addr,   32'h0000_0000);

        // Asynchronous reset in the middle of S_WAIT
        stall = 1'b1;
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b0, '0);
        chk("pre_arst_valid", {31'b0, if_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req",   {31'b0, imem_req}, 32'd0);
        chk("arst_valid", {31'b0, if_valid}, 32'd0);
        chk("arst_instr", if_instr,          NOP);
        chk("arst_pc",    if_pc,             32'h100);
        chk("arst_pc4",   if_pc_plus4,       32'h104);
        chk("arst_addr",  imem_addr,         32'h100);
        stall = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("post_arst_req",  {31'b0, imem_req}, 32'd1);
        chk("post_arst_addr", imem_addr,         32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
